// File: rtl/keycode_arbiter.sv
// Debounces the four movement keys from two HID slots and picks one command keycode (last pressed wins).
// Also drives a cooldown-gated jump pulse; define KEYCMD_JUMP_REPEAT_EN to make a held W auto-repeat it.
module keycode_arbiter #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int RELEASE_FRAMES  = 2,
  parameter int JUMP_COOLDOWN   = 30,
  parameter int REPEAT_FRAMES   = 15
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode_a,
  input  logic [7:0] keycode_b,
  output logic [7:0] keycode_out,
  output logic [3:0] key_held,
  output logic       jump_pulse
);

  localparam logic [7:0] CODE_A = 8'h04;
  localparam logic [7:0] CODE_D = 8'h07;
  localparam logic [7:0] CODE_W = 8'h1A;
  localparam logic [7:0] CODE_S = 8'h16;

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [3:0] REL_LAST = 4'(RELEASE_FRAMES - 1);

  // Cooldown and repeat timers share one width, sized for the longer of the two periods.
  localparam int TIMER_MAX = (JUMP_COOLDOWN > REPEAT_FRAMES) ? JUMP_COOLDOWN : REPEAT_FRAMES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(JUMP_COOLDOWN);

  typedef enum logic [2:0] {IDLE, OWN_A, OWN_D, OWN_W, OWN_S} state_t;

  state_t state, next_state;
  logic [3:0] present;
  logic [3:0] held_q;
  logic [3:0] rise;
  logic [3:0] cnt [4];
  logic owner_held;
  logic fire;
  logic [TIMER_W-1:0] cooldown;

  // Bit order matches key_held: {S,W,D,A}.
  assign present[0] = (keycode_a == CODE_A) || (keycode_b == CODE_A);
  assign present[1] = (keycode_a == CODE_D) || (keycode_b == CODE_D);
  assign present[2] = (keycode_a == CODE_W) || (keycode_b == CODE_W);
  assign present[3] = (keycode_a == CODE_S) || (keycode_b == CODE_S);

  assign rise = key_held & ~held_q;

  function automatic state_t pick_owner(input logic [3:0] keys);
    state_t result;
    if (keys[0])      result = OWN_A;
    else if (keys[1]) result = OWN_D;
    else if (keys[2]) result = OWN_W;
    else if (keys[3]) result = OWN_S;
    else              result = IDLE;
    return result;
  endfunction

  // Each counter tracks frames where the input disagrees with the held flag; agreement clears it.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      key_held <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (present[i] == key_held[i]) begin
          cnt[i] <= 4'd0;
        end else if (cnt[i] == (key_held[i] ? REL_LAST : DEB_LAST)) begin
          key_held[i] <= ~key_held[i];
          cnt[i]      <= 4'd0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      held_q     <= 4'b0000;
      jump_pulse <= 1'b0;
    end else begin
      state      <= next_state;
      held_q     <= key_held;
      jump_pulse <= fire;
    end
  end

  // A fresh rise always wins over an owner release seen on the same edge.
  always_comb begin
    next_state  = state;
    keycode_out = 8'h00;
    owner_held  = 1'b1;
    case (state)
      OWN_A: begin keycode_out = CODE_A; owner_held = key_held[0]; end
      OWN_D: begin keycode_out = CODE_D; owner_held = key_held[1]; end
      OWN_W: begin keycode_out = CODE_W; owner_held = key_held[2]; end
      OWN_S: begin keycode_out = CODE_S; owner_held = key_held[3]; end
      default: ;
    endcase
    if (|rise)            next_state = pick_owner(rise);
    else if (!owner_held) next_state = pick_owner(key_held);
  end

`ifdef KEYCMD_JUMP_REPEAT_EN
  localparam logic [TIMER_W-1:0] REP_LAST = TIMER_W'(REPEAT_FRAMES - 1);

  logic [TIMER_W-1:0] rep_cnt;
  logic w_own;
  logic rep_due;

  assign w_own   = (state == OWN_W) && key_held[2];
  assign rep_due = w_own && (rep_cnt == REP_LAST);
  assign fire    = (rise[2] || rep_due) && (cooldown == '0);

  // Saturates at the period so a cooldown-blocked repeat fires as soon as the cooldown ends.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)                rep_cnt <= '0;
    else if (!w_own || fire)  rep_cnt <= '0;
    else if (rep_cnt != REP_LAST) rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign fire = rise[2] && (cooldown == '0);
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)                cooldown <= '0;
    else if (fire)            cooldown <= COOL_LOAD;
    else if (cooldown != '0)  cooldown <= cooldown - 1'b1;
  end

endmodule

// File: tb/tb_keycode_arbiter.sv
// Scoreboard bench for keycode_arbiter: each driven frame queues the outputs expected after its edge.
module tb_keycode_arbiter;

  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode_a;
  logic [7:0] keycode_b;
  logic [7:0] keycode_out;
  logic [3:0] key_held;
  logic       jump_pulse;

  typedef struct {
    logic [7:0] out;
    logic [3:0] held;
    logic       jump;
    int         frame;
  } exp_t;

  exp_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;
  int frame_no     = 0;
  int cur_frame    = 0;

  keycode_arbiter dut (
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode_a   (keycode_a),
    .keycode_b   (keycode_b),
    .keycode_out (keycode_out),
    .key_held    (key_held),
    .jump_pulse  (jump_pulse)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s frame %0d: got 0x%0h, expected 0x%0h",
               tag, cur_frame, observed, expected);
    end
  endtask

  // Called at a falling edge; drives n frames and queues what each following rising edge must produce.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int n,
                               input logic [7:0] out, input logic [3:0] held, input logic jump);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      keycode_a = a;
      keycode_b = b;
      frame_no++;
      e.out = out; e.held = held; e.jump = jump; e.frame = frame_no;
      sb.push_back(e);
      @(negedge frame_clk);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cur_frame = e.frame;
        checkOutput("keycode_out", keycode_out, e.out);
        checkOutput("key_held", key_held, e.held);
        checkOutput("jump_pulse", jump_pulse, e.jump);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    keycode_a = 8'h00;
    keycode_b = 8'h00;
    #1;
    checkOutput("reset_out", keycode_out, 8'h00);
    checkOutput("reset_held", key_held, 4'b0000);
    checkOutput("reset_jump", jump_pulse, 1'b0);
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;

    // A press and release latency
    applyStimulus(8'h04, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h04, 8'h00, 1, 8'h00, 4'b0001, 1'b0);
    applyStimulus(8'h04, 8'h00, 3, 8'h04, 4'b0001, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h04, 4'b0001, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h04, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 2, 8'h00, 4'b0000, 1'b0);

    // single-frame glitch on D
    applyStimulus(8'h07, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 3, 8'h00, 4'b0000, 1'b0);

    // hold A, D takes over, D released hands back to A
    applyStimulus(8'h04, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h04, 8'h00, 1, 8'h00, 4'b0001, 1'b0);
    applyStimulus(8'h04, 8'h00, 1, 8'h04, 4'b0001, 1'b0);
    applyStimulus(8'h04, 8'h07, 1, 8'h04, 4'b0001, 1'b0);
    applyStimulus(8'h04, 8'h07, 1, 8'h04, 4'b0011, 1'b0);
    applyStimulus(8'h04, 8'h07, 2, 8'h07, 4'b0011, 1'b0);
    applyStimulus(8'h04, 8'h00, 1, 8'h07, 4'b0011, 1'b0);
    applyStimulus(8'h04, 8'h00, 1, 8'h07, 4'b0001, 1'b0);
    applyStimulus(8'h04, 8'h00, 2, 8'h04, 4'b0001, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h04, 4'b0001, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h04, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h00, 4'b0000, 1'b0);

    // simultaneous A and S, slot swap, then unknown codes
    applyStimulus(8'h04, 8'h16, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h04, 8'h16, 1, 8'h00, 4'b1001, 1'b0);
    applyStimulus(8'h04, 8'h16, 2, 8'h04, 4'b1001, 1'b0);
    applyStimulus(8'h16, 8'h04, 2, 8'h04, 4'b1001, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h04, 4'b1001, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h04, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h2C, 8'h00, 2, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h2C, 2, 8'h00, 4'b0000, 1'b0);

    // W jump, quick re-press inside cooldown, late re-press after cooldown
    applyStimulus(8'h1A, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h1A, 8'h00, 1, 8'h00, 4'b0100, 1'b0);
    applyStimulus(8'h1A, 8'h00, 1, 8'h1A, 4'b0100, 1'b1);
    applyStimulus(8'h1A, 8'h00, 1, 8'h1A, 4'b0100, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h1A, 4'b0100, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h1A, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 3, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h1A, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h1A, 8'h00, 1, 8'h00, 4'b0100, 1'b0);
    applyStimulus(8'h1A, 8'h00, 2, 8'h1A, 4'b0100, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h1A, 4'b0100, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h1A, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 41, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h1A, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h1A, 8'h00, 1, 8'h00, 4'b0100, 1'b0);
    applyStimulus(8'h1A, 8'h00, 1, 8'h1A, 4'b0100, 1'b1);
    applyStimulus(8'h1A, 8'h00, 1, 8'h1A, 4'b0100, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h1A, 4'b0100, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h1A, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h00, 4'b0000, 1'b0);

    // hold D, asynchronous reset mid-hold, recovery with D still present
    applyStimulus(8'h07, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h07, 8'h00, 1, 8'h00, 4'b0010, 1'b0);
    applyStimulus(8'h07, 8'h00, 2, 8'h07, 4'b0010, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    cur_frame = frame_no;
    checkOutput("async_reset_out", keycode_out, 8'h00);
    checkOutput("async_reset_held", key_held, 4'b0000);
    checkOutput("async_reset_jump", jump_pulse, 1'b0);
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    applyStimulus(8'h07, 8'h00, 1, 8'h00, 4'b0000, 1'b0);
    applyStimulus(8'h07, 8'h00, 1, 8'h00, 4'b0010, 1'b0);
    applyStimulus(8'h07, 8'h00, 1, 8'h07, 4'b0010, 1'b0);

    // reset cleared the cooldown, so W pressed over D jumps at once and takes ownership
    applyStimulus(8'h07, 8'h1A, 1, 8'h07, 4'b0010, 1'b0);
    applyStimulus(8'h07, 8'h1A, 1, 8'h07, 4'b0110, 1'b0);
    applyStimulus(8'h07, 8'h1A, 1, 8'h1A, 4'b0110, 1'b1);
    applyStimulus(8'h07, 8'h1A, 1, 8'h1A, 4'b0110, 1'b0);
    applyStimulus(8'h07, 8'h00, 1, 8'h1A, 4'b0110, 1'b0);
    applyStimulus(8'h07, 8'h00, 1, 8'h1A, 4'b0010, 1'b0);
    applyStimulus(8'h07, 8'h00, 1, 8'h07, 4'b0010, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h07, 4'b0010, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h07, 4'b0000, 1'b0);
    applyStimulus(8'h00, 8'h00, 1, 8'h00, 4'b0000, 1'b0);

    @(posedge frame_clk);
    #2;
    cur_frame = frame_no;
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
